handler_tx_arbiter: RTL
=======================

HANDLER_TX_ARBITER -- requirements
Module: handler_tx_arbiter

Interface
REQ-001 Parameter SHALL be NUM_KERNELS, default 2, number of kernel request ports, legal range 1..16.
REQ-002 Localparam SHALL be KERNEL_WIDTH, equal to 1 if NUM_KERNELS==1, else clog2(NUM_KERNELS).
REQ-003 Port SHALL be clock  in  1  sole clock; all logic sampled on rising edge.
REQ-004 Port SHALL be reset  in  1  reset, synchronous and active-high.
REQ-005 Port SHALL be req_valid  in  NUM_KERNELS  per-kernel message request.
REQ-006 Port SHALL be req_ready  out  NUM_KERNELS  per-kernel request accepted; one-cycle pulse.
REQ-007 Port SHALL be req_dest  in  16*NUM_KERNELS  per-kernel destination ID; kernel k uses bits [16k+15:16k].
REQ-008 Port SHALL be req_handler  in  4*NUM_KERNELS  per-kernel AM handler ID.
REQ-009 Port SHALL be req_has_payload  in  NUM_KERNELS  1 = payload beats follow the header.
REQ-010 Ports SHALL be pl_tdata  in  64*NUM_KERNELS; pl_tvalid  in  NUM_KERNELS; pl_tlast  in  NUM_KERNELS; pl_tready  out  NUM_KERNELS: per-kernel payload AXIS.
REQ-011 Ports SHALL be axis_handler_tdata  out  64; axis_handler_tvalid  out  1; axis_handler_tlast  out  1; axis_handler_tready  in  1: merged handler stream.
REQ-012 Port SHALL be address_offset  in  16  base ID of this node's kernels.

Function
REQ-013 States SHALL be ST_IDLE, ST_HEADER, ST_PAYLOAD, held in one registered state variable.
REQ-014 ST_IDLE: if any req_valid is set, the block SHALL grant one kernel by round-robin, starting at rr_ptr and wrapping at NUM_KERNELS-1 to 0.
REQ-015 ST_IDLE with a grant: the block SHALL register the grant index, the header and has_payload, and SHALL enter ST_HEADER on the next cycle; with no req_valid it SHALL stay in ST_IDLE.
REQ-016 Header layout SHALL be: [59:56] = req_handler[g]; [39:24] = req_dest[g]; [15:0] = address_offset + g, truncated mod 2^16; all other bits 0.
REQ-017 ST_HEADER: axis_handler_tvalid SHALL be 1, tdata SHALL be the registered header, and tlast SHALL be the inverse of the registered has_payload.
REQ-018 The registered header SHALL stay stable until the tvalid&tready handshake completes.
REQ-019 On the header handshake, req_ready[g] SHALL pulse high for exactly that cycle.
REQ-020 On the header handshake, the next state SHALL be ST_PAYLOAD if has_payload=1, else ST_IDLE.
REQ-021 ST_PAYLOAD SHALL be a combinational pass-through from the granted kernel: axis_handler_tdata=pl_tdata[g], tvalid=pl_tvalid[g], tlast=pl_tlast[g], pl_tready[g]=axis_handler_tready.
REQ-022 In every state, pl_tready SHALL be 0 for every non-granted kernel, and for all kernels outside ST_PAYLOAD.
REQ-023 ST_PAYLOAD: on the handshake of a beat with tlast=1, the block SHALL return to ST_IDLE.
REQ-024 Every return to ST_IDLE SHALL set rr_ptr to (g+1) mod NUM_KERNELS.
REQ-025 The grant SHALL be locked for the whole message; other kernels' req_valid SHALL be ignored until the block is back in ST_IDLE.
REQ-026 Minimum request-to-header latency SHALL be 1 cycle: req_valid sampled in ST_IDLE at edge t gives axis_handler_tvalid=1 from edge t+1.
REQ-027 A header-only message SHALL occupy 2 cycles minimum (IDLE, HEADER), so the next grant may issue on the cycle after the header handshake.
REQ-028 Outside ST_HEADER and ST_PAYLOAD, axis_handler_tvalid SHALL be 0 and tdata/tlast SHALL be 0.
REQ-029 Deasserting req_valid[g] after the grant SHALL NOT abort the message.

Reset
REQ-030 On reset the block SHALL set: state=ST_IDLE, rr_ptr=0, grant=0, header register=0, has_payload=0.
REQ-031 During and after reset, all outputs SHALL be 0: axis_handler_tvalid, axis_handler_tlast, axis_handler_tdata, req_ready, pl_tready.
REQ-032 Reset asserted mid-message SHALL abandon the message, with tvalid=0 from the next edge; no recovery tlast is emitted.

Verification
REQ-033 Scenario: NUM_KERNELS=2, offset=0x0010, kernel1 sends dest=0x0013, handler=0x5, has_payload=0, tready=1 -> one beat with tdata=0x0500_0000_1300_0011, tlast=1; req_ready[1] pulses once.
REQ-034 Scenario: kernel0 with has_payload=1 and 3 payload beats 0xA,0xB,0xC (last on 0xC) -> 4 output beats, header then A,B,C, tlast only on C; pl_tready[1]=0 throughout.
REQ-035 Scenario: both kernels request on the same cycle after reset -> kernel0 message first, kernel1 message second; with both held high continuously, grants alternate 0,1,0,1.
REQ-036 Scenario: tready=0 for 5 cycles during ST_HEADER and mid-payload -> tdata/tvalid/tlast stable; no beat lost or duplicated; req_ready pulses only at the handshake.
REQ-037 Scenario: offset=0xFFFF, kernel1 header -> source field [15:0]=0x0000 (wrap).
REQ-038 Scenario: reset pulsed during the second payload beat -> tvalid=0 on the next edge; a later kernel1 request completes normally, granted from rr_ptr=0.

Source files
------------

// File: rtl/handler_tx_arbiter_if.sv
// Bundle of kernel request ports, per-kernel payload streams and the merged
// handler stream. The arbiter takes the master side; kernels/sink the slave side.
interface handler_tx_arbiter_if #(
  parameter int NUM_KERNELS = 2
);
  logic [NUM_KERNELS-1:0]      req_valid;
  logic [NUM_KERNELS-1:0]      req_ready;
  logic [16*NUM_KERNELS-1:0]   req_dest;
  logic [4*NUM_KERNELS-1:0]    req_handler;
  logic [NUM_KERNELS-1:0]      req_has_payload;
  logic [64*NUM_KERNELS-1:0]   pl_tdata;
  logic [NUM_KERNELS-1:0]      pl_tvalid;
  logic [NUM_KERNELS-1:0]      pl_tlast;
  logic [NUM_KERNELS-1:0]      pl_tready;
  logic [63:0]                 axis_handler_tdata;
  logic                        axis_handler_tvalid;
  logic                        axis_handler_tlast;
  logic                        axis_handler_tready;
  logic [15:0]                 address_offset;

  modport master (
    input  req_valid, req_dest, req_handler, req_has_payload,
    input  pl_tdata, pl_tvalid, pl_tlast, axis_handler_tready, address_offset,
    output req_ready, pl_tready,
    output axis_handler_tdata, axis_handler_tvalid, axis_handler_tlast
  );

  modport slave (
    output req_valid, req_dest, req_handler, req_has_payload,
    output pl_tdata, pl_tvalid, pl_tlast, axis_handler_tready, address_offset,
    input  req_ready, pl_tready,
    input  axis_handler_tdata, axis_handler_tvalid, axis_handler_tlast
  );
endinterface

// File: rtl/handler_tx_arbiter.sv
// Round-robin arbiter merging per-kernel AM requests into one handler stream:
// a registered header beat, then an optional pass-through payload from the winner.
// Handshake: a beat transfers on any rising edge where tvalid and tready are both 1;
// req_ready[g] is high exactly in the cycle the header beat transfers.
module handler_tx_arbiter #(
  parameter int NUM_KERNELS = 2,
  localparam int KERNEL_WIDTH = (NUM_KERNELS == 1) ? 1 : $clog2(NUM_KERNELS)
) (
  input  logic                 clock,
  input  logic                 reset,
  handler_tx_arbiter_if.master bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t                  state_q;
  logic [KERNEL_WIDTH-1:0] rr_ptr_q;
  logic [KERNEL_WIDTH-1:0] grant_q;
  logic [63:0]             header_q;
  logic                    has_payload_q;

  logic                    found_d;
  logic [KERNEL_WIDTH-1:0] pick_d;
  logic [KERNEL_WIDTH-1:0] rr_next_d;
  logic [63:0]             header_d;
  int                      cand;

  // Scan from rr_ptr upward, wrapping, and take the first requester.
  always_comb begin
    found_d = 1'b0;
    pick_d  = '0;
    cand    = 0;
    for (int i = 0; i < NUM_KERNELS; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_KERNELS) cand = cand - NUM_KERNELS;
      if (!found_d && bus.req_valid[cand]) begin
        found_d = 1'b1;
        pick_d  = KERNEL_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    header_d        = 64'd0;
    header_d[59:56] = bus.req_handler[4*int'(pick_d) +: 4];
    header_d[39:24] = bus.req_dest[16*int'(pick_d) +: 16];
    header_d[15:0]  = bus.address_offset + 16'(pick_d);
  end

  assign rr_next_d = (int'(grant_q) == NUM_KERNELS - 1) ? '0 : grant_q + KERNEL_WIDTH'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      header_q      <= 64'd0;
      has_payload_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found_d) begin
            grant_q       <= pick_d;
            header_q      <= header_d;
            has_payload_q <= bus.req_has_payload[pick_d];
            state_q       <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (bus.axis_handler_tready) begin
            if (has_payload_q) begin
              state_q <= ST_PAYLOAD;
            end else begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= rr_next_d;
            end
          end
        end
        ST_PAYLOAD: begin
          if (bus.pl_tvalid[grant_q] && bus.pl_tlast[grant_q] && bus.axis_handler_tready) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= rr_next_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held so nothing leaks mid-abort.
  always_comb begin
    bus.axis_handler_tdata  = 64'd0;
    bus.axis_handler_tvalid = 1'b0;
    bus.axis_handler_tlast  = 1'b0;
    bus.req_ready           = '0;
    bus.pl_tready           = '0;
    if (!reset) begin
      case (state_q)
        ST_HEADER: begin
          bus.axis_handler_tdata  = header_q;
          bus.axis_handler_tvalid = 1'b1;
          bus.axis_handler_tlast  = ~has_payload_q;
          bus.req_ready[grant_q]  = bus.axis_handler_tready;
        end
        ST_PAYLOAD: begin
          bus.axis_handler_tdata  = bus.pl_tdata[64*int'(grant_q) +: 64];
          bus.axis_handler_tvalid = bus.pl_tvalid[grant_q];
          bus.axis_handler_tlast  = bus.pl_tlast[grant_q];
          bus.pl_tready[grant_q]  = bus.axis_handler_tready;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state_o = state_q;

endmodule
